// File: rtl/tia_fb_writer.sv
// tia_fb_writer: TIA pixel strobes (pix_*, hblank/vblank/vsync) -> x/y capture -> FIFO -> valid/ready frame-buffer writes (fb_*), plus frame_done/overflow/frame_count status
module tia_fb_writer #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic [6:0]  pix_color,
  input  logic        hblank,
  input  logic        vblank,
  input  logic        vsync,
  output logic        fb_we,
  output logic [15:0] fb_addr,
  output logic [6:0]  fb_data,
  input  logic        fb_ready,
  output logic        frame_done,
  output logic        overflow,
  output logic [7:0]  frame_count
);
  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {ST_SYNC, ST_WAIT, ST_ACTIVE, ST_DONE} state_t;
  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [15:0] line_base_q, line_base_d;
  logic vsync_q, hblank_q;
  logic [PW:0] wr_q, wr_d, rd_q, rd_d;
  logic [22:0] mem_q [FIFO_DEPTH];
  logic [22:0] mem_d [FIFO_DEPTH];
  logic frame_done_q, frame_done_d, overflow_q, overflow_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic vs_rise, hb_rise, pix_ok, push, pop, full, empty;
  assign vs_rise = vsync & ~vsync_q;
  assign hb_rise = hblank & ~hblank_q;
  assign pix_ok  = pix_valid & ~hblank & ~vblank;
  assign empty   = wr_q == rd_q;
  assign full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign pop     = ~empty & fb_ready;
  assign fb_we       = ~empty;
  assign fb_addr     = mem_q[rd_q[PW-1:0]][22:7];
  assign fb_data     = mem_q[rd_q[PW-1:0]][6:0];
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    line_base_d   = line_base_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    push          = 1'b0;
    if (vs_rise) begin
      state_d     = ST_WAIT;
      x_d         = '0;
      y_d         = '0;
      line_base_d = '0;
    end else begin
      case (state_q)
        ST_WAIT: if (pix_ok) begin
          push    = 1'b1;
          state_d = ST_ACTIVE;
        end
        ST_ACTIVE: if (pix_ok && x_q < XW'(WIDTH)) begin
          push = 1'b1;
        end else if (hb_rise && x_q != '0) begin
          x_d         = '0;
          y_d         = y_q + YW'(1);
          line_base_d = line_base_q + 16'(WIDTH);
          if (y_q == YW'(HEIGHT - 1)) begin
            state_d       = ST_DONE;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
    if (push) x_d = x_q + XW'(1);
  end
  always_comb begin
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = pop ? rd_q + (PW+1)'(1) : rd_q;
    overflow_d = overflow_q | (push & full & ~pop);
    if (push && (!full || pop)) begin
      mem_d[wr_q[PW-1:0]] = {line_base_q + 16'(x_q), pix_color};
      wr_d                = wr_q + (PW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_SYNC;
      x_q           <= '0;
      y_q           <= '0;
      line_base_q   <= '0;
      vsync_q       <= 1'b0;
      hblank_q      <= 1'b0;
      wr_q          <= '0;
      rd_q          <= '0;
      mem_q         <= '{default: '0};
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_base_q   <= line_base_d;
      vsync_q       <= vsync;
      hblank_q      <= hblank;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      mem_q         <= mem_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
    end
  end
endmodule

// File: tb/tb_tia_fb_writer.sv
// tb_tia_fb_writer: directed self-checking bench for tia_fb_writer
module tb_tia_fb_writer;
  logic clk = 0, reset = 1, pix_valid = 0, hblank = 1, vblank = 0, vsync = 0, fb_ready = 1;
  logic [6:0] pix_color = '0;
  logic fb_we, frame_done, overflow;
  logic [15:0] fb_addr;
  logic [6:0] fb_data;
  logic [7:0] frame_count;
  int n_cmp = 0, n_err = 0, fd_cnt = 0;
  logic [15:0] wa [$];
  logic [6:0] wd [$];
  tia_fb_writer dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_color(pix_color),
    .hblank(hblank), .vblank(vblank), .vsync(vsync), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
    .frame_done(frame_done), .overflow(overflow), .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!reset && fb_we && fb_ready) begin
      wa.push_back(fb_addr);
      wd.push_back(fb_data);
    end
    if (!reset && frame_done) fd_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pix(input logic [6:0] c);
    pix_valid = 1;
    pix_color = c;
    tick();
    pix_valid = 0;
  endtask
  task automatic line(input int n);
    hblank = 0;
    for (int i = 0; i < n; i++) pix(7'(i));
    hblank = 1;
    tick();
    tick();
  endtask
  task automatic vs_pulse();
    vsync = 1;
    tick();
    vsync = 0;
    tick();
  endtask
  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask
  initial begin
    int bad;
    tick();
    tick();
    reset = 0;
    chk("rst_we", fb_we, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_data", fb_data, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_fcnt", frame_count, 0);
    // two lines
    vs_pulse();
    clear_log();
    line(160);
    line(160);
    tick();
    chk("t1_count", wa.size(), 320);
    bad = 0;
    foreach (wa[i]) if (wa[i] != 16'(i)) bad++;
    chk("t1_order", bad, 0);
    chk("t1_data165", wd[165], 5);
    chk("t1_ovf", overflow, 0);
    // full frame with an out-of-range pixel on line 3
    vs_pulse();
    clear_log();
    fd_cnt = 0;
    for (int l = 0; l < 240; l++) line(l == 3 ? 201 : 160);
    chk("t2_count", wa.size(), 38400);
    bad = 0;
    foreach (wa[i]) if (wa[i] != 16'(i) || wd[i] != 7'(i % 160)) bad++;
    chk("t2_order", bad, 0);
    chk("t2_last", wa[$], 38399);
    chk("t2_fdone", fd_cnt, 1);
    chk("t2_fcnt", frame_count, 1);
    line(160);
    chk("t2_extra_line", wa.size(), 38400);
    // backpressure
    vs_pulse();
    clear_log();
    fb_ready = 0;
    hblank = 0;
    for (int i = 0; i < 10; i++) begin
      pix(7'(10 + i));
      if (i == 5) begin
        chk("t3_stall_we", fb_we, 1);
        chk("t3_stall_addr", fb_addr, 0);
        chk("t3_stall_data", fb_data, 10);
      end
    end
    chk("t3_stall_addr_end", fb_addr, 0);
    chk("t3_ovf", overflow, 1);
    fb_ready = 1;
    repeat (6) tick();
    chk("t3_drained", wa.size(), 4);
    bad = 0;
    foreach (wa[i]) if (wa[i] != 16'(i) || wd[i] != 7'(10 + i)) bad++;
    chk("t3_order", bad, 0);
    pix(7'd99);
    tick();
    tick();
    chk("t3_next_addr", wa[$], 10);
    chk("t3_next_data", wd[$], 99);
    hblank = 1;
    tick();
    // vsync mid-frame at y = 100
    vs_pulse();
    fd_cnt = 0;
    for (int l = 0; l < 100; l++) line(160);
    clear_log();
    fb_ready = 0;
    hblank = 0;
    pix(7'd40);
    pix(7'd41);
    pix(7'd42);
    vs_pulse();
    chk("t4_queued_we", fb_we, 1);
    fb_ready = 1;
    repeat (5) tick();
    chk("t4_drain_n", wa.size(), 3);
    chk("t4_drain_first", wa[0], 16000);
    chk("t4_drain_last", wa[2], 16002);
    pix(7'd77);
    tick();
    tick();
    chk("t4_restart_addr", wa[$], 0);
    chk("t4_restart_data", wd[$], 77);
    chk("t4_no_fdone", fd_cnt, 0);
    hblank = 1;
    tick();
    // reset with entries queued at y = 50
    vs_pulse();
    for (int l = 0; l < 50; l++) line(160);
    fb_ready = 0;
    hblank = 0;
    pix(7'd1);
    pix(7'd2);
    pix(7'd3);
    chk("t5_pre_we", fb_we, 1);
    chk("t5_pre_addr", fb_addr, 8000);
    reset = 1;
    tick();
    reset = 0;
    chk("t5_we", fb_we, 0);
    chk("t5_addr", fb_addr, 0);
    chk("t5_data", fb_data, 0);
    chk("t5_ovf", overflow, 0);
    chk("t5_fcnt", frame_count, 0);
    chk("t5_fdone", frame_done, 0);
    fb_ready = 1;
    clear_log();
    for (int i = 0; i < 5; i++) pix(7'(20 + i));
    tick();
    tick();
    chk("t5_ignored", wa.size(), 0);
    hblank = 1;
    tick();
    vs_pulse();
    hblank = 0;
    pix(7'd33);
    tick();
    tick();
    chk("t5_after_vs_n", wa.size(), 1);
    chk("t5_after_vs_addr", wa[0], 0);
    hblank = 1;
    tick();
    // blanked pixels and empty hblank pulses
    vs_pulse();
    clear_log();
    hblank = 0;
    vblank = 1;
    for (int i = 0; i < 5; i++) pix(7'd50);
    tick();
    chk("t6_vblank_wait", wa.size(), 0);
    vblank = 0;
    pix(7'd1);
    hblank = 1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      hblank = 0;
      tick();
      hblank = 1;
      tick();
    end
    pix(7'd60);
    hblank = 0;
    vblank = 1;
    pix(7'd61);
    pix(7'd62);
    tick();
    chk("t6_blank_drop", wa.size(), 1);
    vblank = 0;
    pix(7'd9);
    tick();
    tick();
    chk("t6_count", wa.size(), 2);
    chk("t6_addr", wa[$], 160);
    chk("t6_data", wd[$], 9);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
